// File: rtl/mem_line_ctrl_pkg.sv
// rtl/mem_line_ctrl_pkg.sv - shared constants, request ops and FSM states for the line controller
package mem_line_ctrl_pkg;

  localparam int DEF_ADDRESSBIT       = 16;
  localparam int DEF_WORDSIZE         = 32;
  localparam int DEF_LINE_WORDS       = 4;
  localparam int DEF_MEM_ACCESS_DELAY = 4;

  localparam logic RD = 1'b0;
  localparam logic WT = 1'b1;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_FILL  = 2'b01,
    OP_WB    = 2'b10,
    OP_EVICT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WB,
    ST_FILL,
    ST_DONE
  } state_e;

  // Two cycles beyond the memory delay so read data has settled before capture.
  function automatic int hold_cycles(input int delay);
    return delay + 2;
  endfunction

endpackage

// File: rtl/mem_line_ctrl_word_xfer.sv
// rtl/mem_line_ctrl_word_xfer.sv - holds one word access on the memory port and strobes its completion
module mem_line_ctrl_word_xfer
  import mem_line_ctrl_pkg::*;
#(
  parameter int ADDRESSBIT       = DEF_ADDRESSBIT,
  parameter int WORDSIZE         = DEF_WORDSIZE,
  parameter int MEM_ACCESS_DELAY = DEF_MEM_ACCESS_DELAY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDRESSBIT-1:0] addr_i,
  input  logic                  rdwt_i,
  input  logic [WORDSIZE-1:0]   data_i,
  output logic                  word_done_o,
  output logic [ADDRESSBIT-1:0] mem_addr_o,
  output logic                  mem_rdwt_o,
  output logic [WORDSIZE-1:0]   mem_data_o
);

  localparam int HOLD = hold_cycles(MEM_ACCESS_DELAY);
  localparam int CW   = $clog2(HOLD + 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  active_q, active_d;
  logic [ADDRESSBIT-1:0] addr_q, addr_d;
  logic                  rdwt_q, rdwt_d;
  logic [WORDSIZE-1:0]   data_q, data_d;

  assign word_done_o = active_q && (cnt_q == CW'(HOLD - 1));
  assign mem_addr_o  = addr_q;
  assign mem_rdwt_o  = rdwt_q;
  assign mem_data_o  = data_q;

  // A start on the completing cycle chains straight into the next word with no RD gap.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    addr_d   = addr_q;
    rdwt_d   = rdwt_q;
    data_d   = data_q;
    if (start_i) begin
      cnt_d    = '0;
      active_d = 1'b1;
      addr_d   = addr_i;
      rdwt_d   = rdwt_i;
      if (rdwt_i == WT) begin
        data_d = data_i;
      end
    end else if (word_done_o) begin
      cnt_d    = '0;
      active_d = 1'b0;
      rdwt_d   = RD;
    end else if (active_q) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      addr_q   <= '0;
      rdwt_q   <= RD;
      data_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      addr_q   <= addr_d;
      rdwt_q   <= rdwt_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/mem_line_ctrl.sv
// rtl/mem_line_ctrl.sv - sequences line fill, writeback and evict requests into word accesses
module mem_line_ctrl
  import mem_line_ctrl_pkg::*;
#(
  parameter int ADDRESSBIT       = DEF_ADDRESSBIT,
  parameter int WORDSIZE         = DEF_WORDSIZE,
  parameter int LINE_WORDS       = DEF_LINE_WORDS,
  parameter int MEM_ACCESS_DELAY = DEF_MEM_ACCESS_DELAY
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [1:0]                     req_op,
  input  logic [ADDRESSBIT-1:0]          req_fill_addr,
  input  logic [ADDRESSBIT-1:0]          req_wb_addr,
  input  logic [LINE_WORDS*WORDSIZE-1:0] wb_line,
  output logic                           done,
  output logic [LINE_WORDS*WORDSIZE-1:0] fill_line,
  output logic [ADDRESSBIT-1:0]          memAddr,
  output logic [WORDSIZE-1:0]            memDataOut,
  output logic                           memRdwt,
  input  logic [WORDSIZE-1:0]            memDataIn
);

  localparam int IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LW = LINE_WORDS * WORDSIZE;
  localparam logic [ADDRESSBIT-1:0] OFS_MASK = ADDRESSBIT'(LINE_WORDS - 1);
  localparam logic [IW-1:0]         LAST     = IW'(LINE_WORDS - 1);

  state_e                state_q;
  logic [IW-1:0]         idx_q;
  logic                  evict_q;
  logic [ADDRESSBIT-1:0] fill_base_q, wb_base_q;
  logic [LW-1:0]         wb_line_q, buf_q, fill_line_q;
  logic                  done_q, ready_q;

  op_e                   op;
  logic                  accept, word_done, last_word;
  logic [IW-1:0]         idx_nxt;
  logic                  xfer_start, xfer_rdwt;
  logic [ADDRESSBIT-1:0] xfer_addr;
  logic [WORDSIZE-1:0]   xfer_data;
  logic [LW-1:0]         buf_merged;

  assign op        = op_e'(req_op);
  assign accept    = req_valid && ready_q;
  assign last_word = (idx_q == LAST);
  assign idx_nxt   = last_word ? '0 : idx_q + IW'(1);

  assign req_ready = ready_q;
  assign done      = done_q;
  assign fill_line = fill_line_q;

  always_comb begin
    buf_merged = buf_q;
    buf_merged[int'(idx_q)*WORDSIZE +: WORDSIZE] = memDataIn;
  end

  // Next word to put on the bus; the accept edge uses the raw request inputs.
  always_comb begin
    xfer_start = 1'b0;
    xfer_addr  = fill_base_q;
    xfer_rdwt  = RD;
    xfer_data  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_FILL: begin
              xfer_start = 1'b1;
              xfer_addr  = req_fill_addr & ~OFS_MASK;
            end
            OP_WB, OP_EVICT: begin
              xfer_start = 1'b1;
              xfer_addr  = req_wb_addr & ~OFS_MASK;
              xfer_rdwt  = WT;
              xfer_data  = wb_line[WORDSIZE-1:0];
            end
            default: ;
          endcase
        end
      end
      ST_WB: begin
        if (word_done) begin
          if (!last_word) begin
            xfer_start = 1'b1;
            xfer_addr  = wb_base_q | ADDRESSBIT'(idx_nxt);
            xfer_rdwt  = WT;
            xfer_data  = wb_line_q[int'(idx_nxt)*WORDSIZE +: WORDSIZE];
          end else if (evict_q) begin
            xfer_start = 1'b1;
            xfer_addr  = fill_base_q;
          end
        end
      end
      ST_FILL: begin
        if (word_done && !last_word) begin
          xfer_start = 1'b1;
          xfer_addr  = fill_base_q | ADDRESSBIT'(idx_nxt);
        end
      end
      default: ;
    endcase
  end

  mem_line_ctrl_word_xfer #(
    .ADDRESSBIT      (ADDRESSBIT),
    .WORDSIZE        (WORDSIZE),
    .MEM_ACCESS_DELAY(MEM_ACCESS_DELAY)
  ) u_xfer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (xfer_start),
    .addr_i     (xfer_addr),
    .rdwt_i     (xfer_rdwt),
    .data_i     (xfer_data),
    .word_done_o(word_done),
    .mem_addr_o (memAddr),
    .mem_rdwt_o (memRdwt),
    .mem_data_o (memDataOut)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      evict_q     <= 1'b0;
      fill_base_q <= '0;
      wb_base_q   <= '0;
      wb_line_q   <= '0;
      buf_q       <= '0;
      fill_line_q <= '0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            wb_line_q   <= wb_line;
            fill_base_q <= req_fill_addr & ~OFS_MASK;
            wb_base_q   <= req_wb_addr & ~OFS_MASK;
            idx_q       <= '0;
            evict_q     <= (op == OP_EVICT);
            ready_q     <= 1'b0;
            case (op)
              OP_FILL:         state_q <= ST_FILL;
              OP_WB, OP_EVICT: state_q <= ST_WB;
              default:         state_q <= ST_DONE;
            endcase
          end
        end
        ST_WB: begin
          if (word_done) begin
            idx_q <= idx_nxt;
            if (last_word) begin
              if (evict_q) begin
                state_q <= ST_FILL;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        ST_FILL: begin
          if (word_done) begin
            buf_q <= buf_merged;
            idx_q <= idx_nxt;
            if (last_word) begin
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              fill_line_q <= buf_merged;
            end
          end
        end
        // A NOP arrives here with done low, so it spends one extra cycle raising the pulse.
        ST_DONE: begin
          if (done_q) begin
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// tb/tb_mem_line_ctrl.sv - directed and randomized bench for mem_line_ctrl with a behavioural memory
module tb_mem_line_ctrl;

  localparam int AW   = 16;
  localparam int W    = 32;
  localparam int N    = 4;
  localparam int DLY  = 4;
  localparam int HOLD = DLY + 2;
  localparam int LWB  = N * W;
  localparam logic RDV = 1'b0;
  localparam logic WTV = 1'b1;
  localparam logic [1:0] NOP = 2'b00, FILL = 2'b01, WB = 2'b10, EVICT = 2'b11;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [1:0]     req_op = 2'b00;
  logic [AW-1:0]  req_fill_addr = '0;
  logic [AW-1:0]  req_wb_addr = '0;
  logic [LWB-1:0] wb_line = '0;
  logic           done;
  logic [LWB-1:0] fill_line;
  logic [AW-1:0]  memAddr;
  logic [W-1:0]   memDataOut;
  logic           memRdwt;
  logic [W-1:0]   memDataIn = '0;

  always #5 clk = ~clk;

  mem_line_ctrl #(
    .ADDRESSBIT(AW), .WORDSIZE(W), .LINE_WORDS(N), .MEM_ACCESS_DELAY(DLY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_fill_addr(req_fill_addr), .req_wb_addr(req_wb_addr),
    .wb_line(wb_line), .done(done), .fill_line(fill_line), .memAddr(memAddr),
    .memDataOut(memDataOut), .memRdwt(memRdwt), .memDataIn(memDataIn)
  );

  // Memory: any change of addr/rdwt/data re-arms the delay; afterwards the access repeats every edge.
  logic [W-1:0]  mem [0:65535];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [W-1:0]  pl_data = '0;
  logic [AW-1:0] m_addr_p = '0;
  logic          m_rdwt_p = 1'b1;
  logic [W-1:0]  m_data_p = '0;
  int            m_cnt = 0;

  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (memAddr !== m_addr_p || memRdwt !== m_rdwt_p || memDataOut !== m_data_p) begin
      m_addr_p <= memAddr;
      m_rdwt_p <= memRdwt;
      m_data_p <= memDataOut;
      m_cnt    <= 1;
    end else if (m_cnt < DLY) begin
      m_cnt <= m_cnt + 1;
    end else if (memRdwt == WTV) begin
      mem[memAddr] <= memDataOut;
    end else begin
      memDataIn <= mem[memAddr];
    end
  end

  int             checks = 0;
  int             failures = 0;
  logic [W-1:0]   ref_mem [int];
  logic [LWB-1:0] exp_fill = '0;
  logic [AW-1:0]  exp_addr = '0;
  logic [W-1:0]   exp_data = '0;

  task automatic chk(input string tag, input logic [LWB-1:0] obs, input logic [LWB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
    ref_mem[int'(a)] = d;
  endtask

  task automatic preload_rand(input logic [AW-1:0] base);
    for (int i = 0; i < N; i++) preload(base + AW'(i), $urandom);
  endtask

  // Checks the whole request from the accept edge (next posedge) until req_ready returns.
  task automatic expect_req(input bit keep, input logic [AW-1:0] next_fa);
    logic [1:0]     op;
    logic [AW-1:0]  fb, wbb;
    logic [LWB-1:0] wl, fill_before, fill_after;
    int nwb, nfl, total, seg;
    logic er;
    op  = req_op;
    fb  = req_fill_addr & 16'hFFFC;
    wbb = req_wb_addr & 16'hFFFC;
    wl  = wb_line;
    nwb = (op == WB || op == EVICT) ? N : 0;
    nfl = (op == FILL || op == EVICT) ? N : 0;
    total = (op == NOP) ? 1 : (nwb + nfl) * HOLD;
    for (int i = 0; i < nwb; i++) ref_mem[int'(wbb) + i] = wl[i*W +: W];
    fill_before = exp_fill;
    fill_after  = exp_fill;
    for (int i = 0; i < nfl; i++) fill_after[i*W +: W] = ref_mem[int'(fb) + i];
    @(posedge clk);
    for (int k = 0; k <= total + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (keep) begin
          req_op = FILL; req_fill_addr = next_fa;
        end else begin
          req_valid = 1'b0;
        end
      end
      er = RDV;
      if (op != NOP && k < total) begin
        seg = k / HOLD;
        if (seg < nwb) begin
          exp_addr = wbb + AW'(seg);
          exp_data = wl[seg*W +: W];
          er = WTV;
        end else begin
          exp_addr = fb + AW'(seg - nwb);
        end
      end
      chk("done", done, k == total);
      chk("req_ready", req_ready, k == total + 1);
      chk("memAddr", memAddr, exp_addr);
      chk("memRdwt", memRdwt, er);
      chk("memDataOut", memDataOut, exp_data);
      chk("fill_line", fill_line, (k < total) ? fill_before : fill_after);
    end
    exp_fill = fill_after;
    for (int i = 0; i < nwb; i++) chk("mem_written", mem[wbb + AW'(i)], wl[i*W +: W]);
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] fa, input logic [AW-1:0] wa,
                       input logic [LWB-1:0] wl);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_fill_addr = fa; req_wb_addr = wa; wb_line = wl;
    chk("ready_before_accept", req_ready, 1'b1);
    expect_req(1'b0, '0);
  endtask

  initial begin
    // Reset held for three cycles
    repeat (3) @(negedge clk);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_done2", done, 1'b0);
    chk("rst_rdwt", memRdwt, RDV);
    chk("rst_addr", memAddr, 16'h0000);
    chk("rst_fill", fill_line, '0);

    // Fill with known pattern, unaligned request address
    for (int i = 0; i < N; i++) preload(16'h0040 + AW'(i), 32'hA0 + i);
    issue(FILL, 16'h0042, 16'h0000, '0);
    chk("fill_pattern", fill_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    // Writeback
    issue(WB, 16'h0000, 16'h0101, {32'h44, 32'h33, 32'h22, 32'h11});

    // Evict: writes to 0x200 line then fill from 0x300 line
    preload_rand(16'h0300);
    issue(EVICT, 16'h0300, 16'h0200, {$urandom, $urandom, $urandom, $urandom});

    // Reset in the middle of a fill
    preload_rand(16'h0500);
    @(negedge clk);
    req_valid = 1'b1; req_op = FILL; req_fill_addr = 16'h0500;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", req_ready, 1'b1);
    chk("midrst_done", done, 1'b0);
    chk("midrst_addr", memAddr, 16'h0000);
    chk("midrst_rdwt", memRdwt, RDV);
    chk("midrst_dout", memDataOut, '0);
    chk("midrst_fill", fill_line, '0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_done", done, 1'b0);
    end
    rst_n = 1'b1;
    exp_fill = '0; exp_addr = '0; exp_data = '0;
    repeat (30) begin
      @(negedge clk);
      chk("post_rst_no_done", done, 1'b0);
    end

    // Top-of-memory line
    preload_rand(16'hFFFC);
    issue(FILL, 16'hFFFE, 16'h0000, '0);

    // Held req_valid: second FILL accepted the cycle after the first done
    preload_rand(16'h0400);
    preload_rand(16'h0410);
    @(negedge clk);
    req_valid = 1'b1; req_op = FILL; req_fill_addr = 16'h0401;
    chk("held_ready", req_ready, 1'b1);
    expect_req(1'b1, 16'h0413);
    expect_req(1'b0, '0);

    // NOP
    issue(NOP, 16'h0800, 16'h0900, '0);

    // Randomized requests
    for (int r = 0; r < 4; r++) begin
      logic [1:0]    rop;
      logic [AW-1:0] fa, wa;
      rop = 2'($urandom_range(1, 3));
      fa  = 16'h2000 + AW'(r * 16) + AW'($urandom_range(0, 3));
      wa  = 16'h3000 + AW'(r * 16) + AW'($urandom_range(0, 3));
      preload_rand(fa & 16'hFFFC);
      issue(rop, fa, wa, {$urandom, $urandom, $urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
